// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises a raw asynchronous input into clk and accepts a
// level change only after DEBOUNCE_CYCLES consecutive synchronised samples agree.
module switch_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out,
  output logic busy,
  output logic glitch
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   sig_out_next;
  logic                   glitch_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
    end
  end

  // Only the last synchroniser stage is allowed to reach the filter logic.
  assign sync = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
      cnt     <= '0;
      sig_out <= RESET_LEVEL;
      glitch  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sig_out <= sig_out_next;
      glitch  <= glitch_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    sig_out_next = sig_out;
    glitch_next  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync) begin
          state_next = QUAL_HI;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      QUAL_HI: begin
        if (!sync) begin
          state_next  = STABLE_LO;
          cnt_next    = '0;
          glitch_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next   = STABLE_HI;
          sig_out_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          state_next = QUAL_LO;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      QUAL_LO: begin
        if (sync) begin
          state_next  = STABLE_HI;
          cnt_next    = '0;
          glitch_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next   = STABLE_LO;
          sig_out_next = 1'b0;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  // Decoded from the state register alone so busy never sees sig_in combinationally.
  assign busy = (state == QUAL_HI) || (state == QUAL_LO);

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a default instance and a DEBOUNCE_CYCLES=2 /
// SYNC_STAGES=3 instance share one stimulus; a run-length model feeds a scoreboard.
module tb_switch_debouncer;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_in;
  logic so0, bz0, gl0;
  logic so1, bz1, gl1;

  always #5 clk = ~clk;

  switch_debouncer dut0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .sig_out(so0), .busy(bz0), .glitch(gl0)
  );

  switch_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .sig_out(so1), .busy(bz1), .glitch(gl1)
  );

  typedef struct {
    int   inst;
    logic out;
    logic busy;
    logic glt;
  } exp_t;

  exp_t sbq[$];

  int   checks = 0;
  int   errors = 0;
  int   dcyc[2] = '{16, 2};
  int   sst[2]  = '{2, 3};
  logic [7:0] mpipe[2];
  logic mout[2];
  int   mrun[2];
  logic mglt[2];

  int   ecnt;
  int   g0, g1, r0, r1;
  int   rise0, fall0, rise1;
  logic prev0, prev1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mpipe[i] = 8'h00;
      mout[i]  = 1'b0;
      mrun[i]  = 0;
      mglt[i]  = 1'b0;
    end
  endtask

  task automatic clear_stats();
    ecnt = 0; g0 = 0; g1 = 0; r0 = 0; r1 = 0;
    rise0 = -1; fall0 = -1; rise1 = -1;
  endtask

  // Drive one sample, predict every output after the next edge, then compare.
  task automatic step(input logic v);
    logic fin;
    exp_t e;
    sig_in = v;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mpipe[i] = 8'h00; mout[i] = 1'b0; mrun[i] = 0; mglt[i] = 1'b0;
      end else begin
        fin      = mpipe[i][sst[i]-1];
        mpipe[i] = {mpipe[i][6:0], v};
        mglt[i]  = 1'b0;
        if (fin != mout[i]) begin
          mrun[i]++;
          if (mrun[i] == dcyc[i]) begin
            mout[i] = ~mout[i];
            mrun[i] = 0;
          end
        end else begin
          if (mrun[i] > 0) mglt[i] = 1'b1;
          mrun[i] = 0;
        end
      end
      e.inst = i; e.out = mout[i]; e.busy = (mrun[i] > 0); e.glt = mglt[i];
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    ecnt++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.inst == 0) begin
        check("d16_sig_out", so0, e.out);
        check("d16_busy", bz0, e.busy);
        check("d16_glitch", gl0, e.glt);
      end else begin
        check("d2_sig_out", so1, e.out);
        check("d2_busy", bz1, e.busy);
        check("d2_glitch", gl1, e.glt);
      end
    end
    if (gl0) g0++;
    if (gl1) g1++;
    if (so0 && !prev0) begin r0++; if (rise0 < 0) rise0 = ecnt; end
    if (!so0 && prev0 && fall0 < 0) fall0 = ecnt;
    if (so1 && !prev1) begin r1++; if (rise1 < 0) rise1 = ecnt; end
    prev0 = so0;
    prev1 = so1;
  endtask

  task automatic repeat_step(input logic v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_sig_out"}, so0, 0);
    check({tag, "_busy"}, bz0, 0);
    check({tag, "_glitch"}, gl0, 0);
    model_reset();
    prev0 = 1'b0;
    prev1 = 1'b0;
    repeat_step(1'b1, 2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b1;
    prev0  = 1'b0;
    prev1  = 1'b0;
    model_reset();
    clear_stats();

    // Reset held with sig_in high, then release and watch qualification.
    repeat_step(1'b1, 3);
    check("rst_sig_out", so0, 0);
    check("rst_busy", bz0, 0);
    check("rst_glitch", gl0, 0);
    rst_n = 1'b1;
    clear_stats();
    for (int k = 0; k < 30; k++) begin
      step(1'b1);
      if (ecnt == 2)  check("rel_busy_e2", bz0, 0);
      if (ecnt == 3)  check("rel_busy_e3", bz0, 1);
      if (ecnt == 17) check("rel_busy_e17", bz0, 1);
      if (ecnt == 18) check("rel_busy_e18", bz0, 0);
    end
    check("rel_latency_d16", rise0, 18);
    check("rel_latency_d2", rise1, 5);

    // Clean release then clean press/release.
    repeat_step(1'b0, 40);
    clear_stats();
    repeat_step(1'b1, 40);
    check("press_latency", rise0, 18);
    clear_stats();
    repeat_step(1'b0, 40);
    check("release_latency", fall0, 18);
    check("press_glitches", g0, 0);

    // Threshold: 16 high samples accepted, 15 rejected with one glitch.
    clear_stats();
    repeat_step(1'b1, 16);
    repeat_step(1'b0, 30);
    check("thr16_rises", r0, 1);
    check("thr16_glitches", g0, 0);
    clear_stats();
    repeat_step(1'b1, 15);
    repeat_step(1'b0, 30);
    check("thr15_rises", r0, 0);
    check("thr15_glitches", g0, 1);

    // Bounce: 5 high, 1 low, 3 high, 2 low, then held high.
    clear_stats();
    repeat_step(1'b1, 5);
    repeat_step(1'b0, 1);
    repeat_step(1'b1, 3);
    repeat_step(1'b0, 2);
    check("bounce_no_toggle", r0, 0);
    ecnt = 0;
    rise0 = -1;
    repeat_step(1'b1, 30);
    check("bounce_glitches", g0, 2);
    check("bounce_latency", rise0, 18);
    check("bounce_rises", r0, 1);

    // Async reset inside QUAL_LO with cnt=9, then inside STABLE_HI.
    repeat_step(1'b0, 11);
    check("qlo_busy_before", bz0, 1);
    check("qlo_sig_out_before", so0, 1);
    async_reset("rst_qual_lo");
    repeat_step(1'b1, 25);
    check("shi_sig_out_before", so0, 1);
    async_reset("rst_stable_hi");
    repeat_step(1'b0, 10);

    // Narrow pulses on the DEBOUNCE_CYCLES=2 instance.
    clear_stats();
    repeat_step(1'b0, 10);
    repeat_step(1'b1, 2);
    repeat_step(1'b0, 10);
    check("d2_run2_rises", r1, 1);
    check("d2_run2_glitches", g1, 0);
    clear_stats();
    repeat_step(1'b1, 1);
    repeat_step(1'b0, 10);
    check("d2_run1_rises", r1, 0);
    check("d2_run1_glitches", g1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
